// File: rtl/prio_encoder_rr.sv
// Registered priority encoder, fixed (MSB-first) or round-robin order,
// with valid/ready handshake on both sides.
module prio_encoder_rr #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [IDX_W-1:0] dout,
    output logic             dout_none,
    output logic             dout_valid,
    input  logic             dout_ready
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] dout_q, dout_d;
    logic             none_q, none_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] grant;
    logic             found;
    logic             accept;
    int               idx;

    assign din_ready  = !valid_q || dout_ready;
    assign accept     = din_valid && din_ready;
    assign dout       = dout_q;
    assign dout_none  = none_q;
    assign dout_valid = valid_q;

    // Fixed priority is round-robin with the pointer pinned at 0.
    always_comb begin
        base  = mode ? ptr_q : '0;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx = (int'(base) + WIDTH - k) % WIDTH;
            if (!found && din[IDX_W'(idx)]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        dout_d  = dout_q;
        none_d  = none_q;
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
            none_d  = !found;
            dout_d  = found ? grant : '0;
            if (found) begin
                ptr_d = grant;
            end
        end else if (dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            dout_q  <= '0;
            none_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            none_q  <= none_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: WIDTH=8 and WIDTH=5 instances checked
// against a behavioural arbitration model, directed then random.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [7:0] din8;
    logic [4:0] din5;
    logic       dv8, dv5, dr8, dr5;
    logic       rdy8, rdy5;
    logic [2:0] dout8, dout5;
    logic       none8, none5, val8, val5;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int mptr[2];
    bit mval[2];
    int mdout[2];
    bit mnone[2];

    always #5 clk = ~clk;

    prio_encoder_rr #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .mode(mode),
        .din(din8), .din_valid(dv8), .din_ready(rdy8),
        .dout(dout8), .dout_none(none8), .dout_valid(val8),
        .dout_ready(dr8)
    );

    prio_encoder_rr #(.WIDTH(5)) u5 (
        .clk(clk), .rst(rst), .mode(mode),
        .din(din5), .din_valid(dv5), .din_ready(rdy5),
        .dout(dout5), .dout_none(none5), .dout_valid(val5),
        .dout_ready(dr5)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scan w lines downward starting just below the pointer; -1 if none set.
    function automatic int ref_grant(int w, int p, bit m, logic [63:0] d);
        int s;
        int i;
        s = m ? p : 0;
        for (int k = 1; k <= w; k++) begin
            i = ((s - k) % w + w) % w;
            if (d[i[5:0]]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(int n, int w, bit dv, bit drdy,
                              logic [63:0] d, bit m);
        int g;
        if (dv && (!mval[n] || drdy)) begin
            g = ref_grant(w, mptr[n], m, d);
            mval[n] = 1'b1;
            if (g < 0) begin
                mdout[n] = 0;
                mnone[n] = 1'b1;
            end else begin
                mdout[n] = g;
                mnone[n] = 1'b0;
                mptr[n]  = g;
            end
        end else if (drdy) begin
            mval[n] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            mptr[n]  = 0;
            mval[n]  = 1'b0;
            mdout[n] = 0;
            mnone[n] = 1'b0;
        end
    endtask

    task automatic chk_outs();
        chk("val8", 64'(val8), 64'(mval[0]));
        chk("val5", 64'(val5), 64'(mval[1]));
        if (mval[0]) begin
            chk("dout8", 64'(dout8), 64'(mdout[0]));
            chk("none8", 64'(none8), 64'(mnone[0]));
        end
        if (mval[1]) begin
            chk("dout5", 64'(dout5), 64'(mdout[1]));
            chk("none5", 64'(none5), 64'(mnone[1]));
        end
    endtask

    // Inputs are already driven; check ready, clock one edge, check outputs.
    task automatic step();
        chk("rdy8", 64'(rdy8), 64'(!mval[0] || dr8));
        chk("rdy5", 64'(rdy5), 64'(!mval[1] || dr5));
        model_edge(0, 8, dv8, dr8, 64'(din8), mode);
        model_edge(1, 5, dv5, dr5, 64'(din5), mode);
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_val8", 64'(val8), 64'(0));
        chk("rst_dout8", 64'(dout8), 64'(0));
        chk("rst_none8", 64'(none8), 64'(0));
        chk("rst_val5", 64'(val5), 64'(0));
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int exp_seq[$];
        rst  = 1'b1;
        mode = 1'b0;
        din8 = '0;
        din5 = '0;
        dv8  = 1'b0;
        dv5  = 1'b0;
        dr8  = 1'b1;
        dr5  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fixed priority single accept
        din8 = 8'b0010_1100;
        dv8  = 1'b1;
        step();
        chk("t1_dout", 64'(dout8), 64'(5));
        chk("t1_val", 64'(val8), 64'(1));
        dv8 = 1'b0;
        step();
        chk("t1_drop", 64'(val8), 64'(0));

        // Zero input leaves pointer untouched
        do_reset();
        din8 = 8'h00;
        dv8  = 1'b1;
        step();
        chk("t2_none", 64'(none8), 64'(1));
        chk("t2_dout", 64'(dout8), 64'(0));
        mode = 1'b1;
        din8 = 8'hFF;
        step();
        chk("t2_rr7", 64'(dout8), 64'(7));
        chk("t2_none0", 64'(none8), 64'(0));

        // Round-robin sweep over all-ones
        do_reset();
        exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
        foreach (exp_seq[i]) begin
            step();
            chk("t3_rr", 64'(dout8), 64'(exp_seq[i]));
        end

        // Two-line alternation then fixed mode
        do_reset();
        din8    = 8'b1000_0001;
        exp_seq = '{7, 0, 7, 0};
        foreach (exp_seq[i]) begin
            step();
            chk("t4_rr", 64'(dout8), 64'(exp_seq[i]));
        end
        mode = 1'b0;
        repeat (2) begin
            step();
            chk("t4_fix", 64'(dout8), 64'(7));
        end

        // Backpressure
        din8 = 8'h10;
        step();
        chk("t5_first", 64'(dout8), 64'(4));
        din8 = 8'h80;
        dr8  = 1'b0;
        #1;
        repeat (3) begin
            chk("t5_rdy", 64'(rdy8), 64'(0));
            step();
            chk("t5_hold", 64'(dout8), 64'(4));
            chk("t5_hval", 64'(val8), 64'(1));
        end
        dr8 = 1'b1;
        #1;
        step();
        chk("t5_next", 64'(dout8), 64'(7));
        dv8 = 1'b0;
        step();

        // Asynchronous reset mid-operation
        do_reset();
        mode = 1'b1;
        din8 = 8'hFF;
        dv8  = 1'b1;
        step();
        chk("t6_a", 64'(dout8), 64'(7));
        step();
        chk("t6_b", 64'(dout8), 64'(6));
        do_reset();
        step();
        chk("t6_after", 64'(dout8), 64'(7));
        dv8 = 1'b0;
        step();

        // Non-power-of-two width wraps at 5
        do_reset();
        din5    = 5'h1F;
        dv5     = 1'b1;
        exp_seq = '{4, 3, 2, 1, 0, 4};
        foreach (exp_seq[i]) begin
            step();
            chk("t7_w5", 64'(dout5), 64'(exp_seq[i]));
        end

        // Random traffic against the model
        do_reset();
        repeat (400) begin
            mode = 1'($urandom_range(0, 1));
            din8 = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            din5 = ($urandom_range(0, 4) == 0) ? 5'h00 : 5'($urandom);
            dv8  = ($urandom_range(0, 3) != 0);
            dv5  = ($urandom_range(0, 3) != 0);
            dr8  = ($urandom_range(0, 2) != 0);
            dr5  = ($urandom_range(0, 2) != 0);
            #1;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
